// File: rtl/voice_allocator_pkg.sv
// rtl/voice_allocator_pkg.sv - shared defaults and helpers for the voice allocator
// Purpose: default sizing for keyboard/voice bank and the voice_key slice offset helper.
package voice_allocator_pkg;

  localparam int DEF_NUM_KEYS   = 24;
  localparam int DEF_KEY_W      = 5;
  localparam int DEF_NUM_VOICES = 4;
  localparam int DEF_AGE_W      = 8;

  // Low bit of voice v's key index inside the flattened voice_key bus.
  function automatic int key_lsb(input int v, input int key_w);
    return v * key_w;
  endfunction

endpackage

// File: rtl/voice_allocator_lsb_priority_enc.sv
// rtl/voice_allocator_lsb_priority_enc.sv - lowest-set-bit priority encoder
// Purpose: report the index of the lowest set request bit.
// Ports:
//   req   in  WIDTH  request vector
//   idx   out IDX_W  index of lowest set bit (0 when none)
//   valid out 1      any request bit set
module lsb_priority_enc #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
) (
  input  logic [WIDTH-1:0] req,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    // Scan downward so the last hit, the lowest index, wins.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - polyphony scheduler mapping pressed keys onto tone generators
// Purpose: detect key presses/releases, assign new keys to idle voices or steal the oldest.
// Ports:
//   clk          in  1                   system clock
//   rst          in  1                   asynchronous active-high reset
//   keys         in  NUM_KEYS            held key levels
//   voice_key    out NUM_VOICES*KEY_W    key index per voice
//   voice_active out NUM_VOICES          voice sounding
//   voice_start  out NUM_VOICES          one-cycle (re)assignment pulse
//   steal        out 1                   one-cycle pulse when an active voice is taken over
module voice_allocator
  import voice_allocator_pkg::*;
#(
  parameter int NUM_KEYS   = DEF_NUM_KEYS,
  parameter int KEY_W      = DEF_KEY_W,
  parameter int NUM_VOICES = DEF_NUM_VOICES,
  parameter int AGE_W      = DEF_AGE_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_KEYS-1:0]         keys,
  output logic [NUM_VOICES*KEY_W-1:0] voice_key,
  output logic [NUM_VOICES-1:0]       voice_active,
  output logic [NUM_VOICES-1:0]       voice_start,
  output logic                        steal
);

  localparam int VOICE_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int KEY_SPAN = 1 << KEY_W;

  logic [NUM_KEYS-1:0]                keys_q, keys_d;
  logic [NUM_KEYS-1:0]                pending_q, pending_d;
  logic [NUM_VOICES-1:0][KEY_W-1:0]   voice_key_q, voice_key_d;
  logic [NUM_VOICES-1:0]              voice_active_q, voice_active_d;
  logic [NUM_VOICES-1:0]              voice_start_q, voice_start_d;
  logic                               steal_q, steal_d;
  logic [NUM_VOICES-1:0][AGE_W-1:0]   age_q, age_d;

  logic [NUM_KEYS-1:0]   rise, cand;
  logic [KEY_SPAN-1:0]   keys_ext;
  logic [NUM_VOICES-1:0] rel;
  logic [KEY_W-1:0]      cand_idx;
  logic                  cand_valid;
  logic [VOICE_W-1:0]    idle_idx;
  logic                  idle_valid;
  logic [VOICE_W-1:0]    oldest_idx;
  logic [AGE_W-1:0]      oldest_age;
  logic                  assign_en;
  logic [VOICE_W-1:0]    assign_voice;

  assign rise = keys & ~keys_q;
  // A pending key that is no longer held simply falls out here.
  assign cand = (pending_q | rise) & keys;

  lsb_priority_enc #(.WIDTH(NUM_KEYS), .IDX_W(KEY_W)) u_cand_enc (
    .req   (cand),
    .idx   (cand_idx),
    .valid (cand_valid)
  );

  lsb_priority_enc #(.WIDTH(NUM_VOICES), .IDX_W(VOICE_W)) u_idle_enc (
    .req   (~voice_active_q),
    .idx   (idle_idx),
    .valid (idle_valid)
  );

  // Widen keys so any KEY_W-bit index selects a defined bit.
  always_comb begin
    keys_ext = KEY_SPAN'(keys);
    for (int v = 0; v < NUM_VOICES; v++) begin
      rel[v] = voice_active_q[v] & ~keys_ext[voice_key_q[v]];
    end
  end

  // Oldest voice; strict compare keeps the lowest index on ties.
  always_comb begin
    oldest_idx = '0;
    oldest_age = age_q[0];
    for (int v = 1; v < NUM_VOICES; v++) begin
      if (age_q[v] > oldest_age) begin
        oldest_age = age_q[v];
        oldest_idx = VOICE_W'(v);
      end
    end
  end

  // A release this edge means a voice frees up next edge, so stall rather than steal.
  always_comb begin
    assign_en    = 1'b0;
    assign_voice = '0;
    steal_d      = 1'b0;
    if (cand_valid) begin
      if (idle_valid) begin
        assign_en    = 1'b1;
        assign_voice = idle_idx;
      end else if (~|rel) begin
        assign_en    = 1'b1;
        assign_voice = oldest_idx;
        steal_d      = 1'b1;
      end
    end
  end

  always_comb begin
    keys_d         = keys;
    pending_d      = cand;
    voice_key_d    = voice_key_q;
    voice_active_d = voice_active_q & ~rel;
    voice_start_d  = '0;
    age_d          = '0;
    if (assign_en) begin
      pending_d = cand & ~(NUM_KEYS'(1) << cand_idx);
    end
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (assign_en && (assign_voice == VOICE_W'(v))) begin
        voice_key_d[v]    = cand_idx;
        voice_active_d[v] = 1'b1;
        voice_start_d[v]  = 1'b1;
      end
    end
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (voice_start_d[v] || !voice_active_d[v]) begin
        age_d[v] = '0;
      end else if (age_q[v] == {AGE_W{1'b1}}) begin
        age_d[v] = age_q[v];
      end else begin
        age_d[v] = age_q[v] + AGE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      keys_q         <= '0;
      pending_q      <= '0;
      voice_key_q    <= '0;
      voice_active_q <= '0;
      voice_start_q  <= '0;
      steal_q        <= 1'b0;
      age_q          <= '0;
    end else begin
      keys_q         <= keys_d;
      pending_q      <= pending_d;
      voice_key_q    <= voice_key_d;
      voice_active_q <= voice_active_d;
      voice_start_q  <= voice_start_d;
      steal_q        <= steal_d;
      age_q          <= age_d;
    end
  end

  always_comb begin
    voice_key = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      voice_key[key_lsb(v, KEY_W) +: KEY_W] = voice_key_q[v];
    end
  end

  assign voice_active = voice_active_q;
  assign voice_start  = voice_start_q;
  assign steal        = steal_q;

endmodule
